// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: Moore sequencer for the multicycle RV32I datapath.
// Steps the shared ALU and unified memory port, with an optional memory wait handshake.
module riscv_multicycle_ctrl #(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_pc_write,
   output logic       o_adr_src,
   output logic       o_mem_write,
   output logic       o_ir_write,
   output logic [1:0] o_result_src,
   output logic [1:0] o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_imm_src,
   output logic [2:0] o_alu_control,
   output logic       o_reg_write,
   output logic       o_illegal_op,
   output logic [3:0] o_state_dbg
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_t     r_state;
   state_t     w_next;
   logic       w_rdy;
   logic       w_pc_write;
   logic       w_adr_src;
   logic       w_mem_write;
   logic       w_ir_write;
   logic [1:0] w_result_src;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [2:0] w_alu_control;
   logic       w_reg_write;
   logic       w_illegal_op;

   // op[5] separates R-type from I-type so that addi never turns into a subtract
   function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7b5, input logic op5);
      case (f3)
         3'b000:  alu_decode = (f7b5 & op5) ? 3'b001 : 3'b000;
         3'b010:  alu_decode = 3'b101;
         3'b110:  alu_decode = 3'b011;
         3'b111:  alu_decode = 3'b010;
         default: alu_decode = 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] imm_decode(input logic [6:0] op);
      case (op)
         OP_SW:   imm_decode = 2'b01;
         OP_BEQ:  imm_decode = 2'b10;
         OP_JAL:  imm_decode = 2'b11;
         default: imm_decode = 2'b00;
      endcase
   endfunction

   assign w_rdy = i_mem_ready | ~USE_MEM_READY;

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-state control decode
   always_comb begin
      w_next        = r_state;
      w_pc_write    = 1'b0;
      w_adr_src     = 1'b0;
      w_mem_write   = 1'b0;
      w_ir_write    = 1'b0;
      w_result_src  = 2'b00;
      w_alu_src_a   = 2'b00;
      w_alu_src_b   = 2'b00;
      w_alu_control = 3'b000;
      w_reg_write   = 1'b0;
      w_illegal_op  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
            w_ir_write   = w_rdy;
            w_pc_write   = w_rdy;
            w_next       = w_rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
            case (i_op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECR;
               OP_I:         w_next = S_EXECI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
               default: begin
                  w_next       = S_FETCH;
                  w_illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
            w_next      = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_adr_src = 1'b1;
            w_next    = w_rdy ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            w_next      = w_rdy ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            w_alu_src_a   = 2'b10;
            w_alu_control = alu_decode(i_funct3, i_funct7b5, i_op[5]);
            w_next        = S_ALUWB;
         end
         S_EXECI: begin
            w_alu_src_a   = 2'b10;
            w_alu_src_b   = 2'b01;
            w_alu_control = alu_decode(i_funct3, i_funct7b5, i_op[5]);
            w_next        = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_BEQ: begin
            w_alu_src_a   = 2'b10;
            w_alu_control = 3'b001;
            w_pc_write    = i_zero;
            w_next        = S_FETCH;
         end
         S_JAL: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b10;
            w_pc_write  = 1'b1;
            w_next      = S_ALUWB;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // Reset forces every enable and select low without waiting for a clock edge
   assign o_pc_write    = i_reset ? 1'b0  : w_pc_write;
   assign o_adr_src     = i_reset ? 1'b0  : w_adr_src;
   assign o_mem_write   = i_reset ? 1'b0  : w_mem_write;
   assign o_ir_write    = i_reset ? 1'b0  : w_ir_write;
   assign o_result_src  = i_reset ? 2'b00 : w_result_src;
   assign o_alu_src_a   = i_reset ? 2'b00 : w_alu_src_a;
   assign o_alu_src_b   = i_reset ? 2'b00 : w_alu_src_b;
   assign o_imm_src     = i_reset ? 2'b00 : imm_decode(i_op);
   assign o_alu_control = i_reset ? 3'b000 : w_alu_control;
   assign o_reg_write   = i_reset ? 1'b0  : w_reg_write;
   assign o_illegal_op  = i_reset ? 1'b0  : w_illegal_op;
   assign o_state_dbg   = r_state;

endmodule
